// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// gemm_pkg -- shared types and constants for the GEMM result-drain path
// Revision: 1.0
// ============================================================================
package gemm_pkg;

   localparam int WORD_W     = 128;
   localparam int WORD_LANES = 4;

   typedef logic [7:0] dim_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/gemm_word_serializer.sv
`default_nettype none
// ============================================================================
// gemm_word_serializer -- holds one C-memory word and streams its lanes out
// Revision: 1.0
// ============================================================================
module gemm_word_serializer
   import gemm_pkg::*;
#(
   parameter int ELEM_W = 32,
   parameter int LANES  = WORD_LANES,
   parameter int LW     = $clog2(LANES + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [LW-1:0]     nlanes_i,
   input  logic              last_word_i,
   input  logic              out_ready_i,
   output logic              out_valid_o,
   output logic [ELEM_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic              word_done_o
);

   localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [WORD_W-1:0] word_q;
   logic [SW-1:0]     lane_q;
   logic [LW-1:0]     nlanes_q;
   logic              last_word_q;
   logic              valid_q;
   logic              final_lane;
   logic              handshake;
   logic [ELEM_W-1:0] lane_data [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_data[g] = word_q[g*ELEM_W +: ELEM_W];
   end

   // nlanes_q counts only the lanes that lie inside the matrix
   assign final_lane  = (LW'(lane_q) == nlanes_q - LW'(1));
   assign handshake   = valid_q && out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = lane_data[lane_q];
   assign out_last_o  = valid_q && last_word_q && final_lane;
   assign word_done_o = handshake && final_lane;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word_q      <= '0;
         lane_q      <= '0;
         nlanes_q    <= '0;
         last_word_q <= 1'b0;
         valid_q     <= 1'b0;
      end else if (load_i) begin
         word_q      <= word_i;
         lane_q      <= '0;
         nlanes_q    <= nlanes_i;
         last_word_q <= last_word_i;
         valid_q     <= 1'b1;
      end else if (handshake) begin
         if (final_lane) begin
            valid_q <= 1'b0;
         end else begin
            lane_q <= lane_q + SW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gemm_c_drain.sv
`default_nettype none
// ============================================================================
// gemm_c_drain -- reads a row-major result matrix from C memory and streams it
// Revision: 1.0
// ============================================================================
module gemm_c_drain
   import gemm_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int ELEM_W     = 32,
   parameter int LANES      = WORD_LANES
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [7:0]            M_dimmension,
   input  logic [7:0]            N_dimmension,
   input  logic [ADDR_WIDTH-1:0] base_addr_C,
   output logic                  read_enable_C,
   output logic [ADDR_WIDTH-1:0] address_C,
   input  logic [WORD_W-1:0]     data_out_C,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ELEM_W-1:0]     out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int LW = $clog2(LANES + 1);

   state_e                state_q, state_d;
   dim_t                  m_q, n_q, row_q, wcol_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [9:0]            col_base;
   logic [9:0]            cols_left;
   logic                  row_end;
   logic                  mat_end;
   logic [LW-1:0]         nlanes;
   logic                  load;
   logic                  word_done;

   // Lanes past column N-1 in a row's final word are trimmed via nlanes
   assign col_base  = {2'b00, wcol_q} * 10'(LANES);
   assign cols_left = {2'b00, n_q} - col_base;
   assign row_end   = (cols_left <= 10'(LANES));
   assign mat_end   = row_end && (row_q == m_q - 8'd1);
   assign nlanes    = row_end ? cols_left[LW-1:0] : LW'(LANES);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (M_dimmension == 8'd0 || N_dimmension == 8'd0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            load    = 1'b1;
            state_d = EMIT;
         end
         EMIT: begin
            if (word_done) begin
               state_d = mat_end ? DONE : FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         n_q     <= '0;
         row_q   <= '0;
         wcol_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            m_q    <= M_dimmension;
            n_q    <= N_dimmension;
            row_q  <= '0;
            wcol_q <= '0;
            addr_q <= base_addr_C;
         end else if (word_done) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (row_end) begin
               wcol_q <= '0;
               row_q  <= row_q + 8'd1;
            end else begin
               wcol_q <= wcol_q + 8'd1;
            end
         end
      end
   end

   assign read_enable_C = (state_q == FETCH);
   assign address_C     = addr_q;
   assign busy          = (state_q == FETCH) || (state_q == LOAD) || (state_q == EMIT);
   assign done          = (state_q == DONE);

   gemm_word_serializer #(
      .ELEM_W (ELEM_W),
      .LANES  (LANES),
      .LW     (LW)
   ) u_ser (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (load),
      .word_i      (data_out_C),
      .nlanes_i    (nlanes),
      .last_word_i (mat_end),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .word_done_o (word_done)
   );

endmodule
`default_nettype wire
